// File: rtl/multi_channel_delay_timer_pkg.sv
// Shared encodings for the multi-channel delay timer: channel modes and FSM states.
package multi_channel_delay_timer_pkg;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_RETRIG   = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;
    localparam logic [1:0] MODE_OFF      = 2'd3;

    typedef enum logic {
        IDLE,
        RUN
    } chan_state_e;

endpackage

// File: rtl/delay_timer_channel.sv
// One timer channel: trigger edge detect, mode/delay latch, down-counter and expiry pulse.
module delay_timer_channel
    import multi_channel_delay_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             trigger,
    input  logic             cancel,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] delay,
    output logic             pulse,
    output logic             busy
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [1:0]       mode_q, mode_d;
    logic             trig_q;
    logic             pulse_q, pulse_d;
    logic             trig_edge;

    always_comb begin
        trig_edge = trigger & ~trig_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        pulse_d   = 1'b0;

        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig_edge && (mode != MODE_OFF)) begin
                        state_d  = RUN;
                        // A zero delay behaves like a delay of one tick.
                        reload_d = (delay == '0) ? '0 : delay - CNT_W'(1);
                        cnt_d    = reload_d;
                        mode_d   = mode;
                    end
                end
                RUN: begin
                    if (trig_edge && (mode_q == MODE_RETRIG)) begin
                        cnt_d = reload_q;
                    end else if (tick) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            pulse_d = 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                cnt_d = reload_q;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            trig_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            trig_q   <= trigger;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = (state_q == RUN);

endmodule

// File: rtl/multi_channel_delay_timer.sv
// CHANNELS independent programmable delay timers sharing one free-running tick prescaler.
module multi_channel_delay_timer
    import multi_channel_delay_timer_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS-1:0]       cancel,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CNT_W*CHANNELS-1:0] delay,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       busy
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    // With PRESCALE=1 the counter sits at zero and tick is permanently high.
    always_comb begin
        tick  = (pre_q == PRE_W'(PRESCALE - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        delay_timer_channel #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .trigger(trigger[i]),
            .cancel (cancel[i]),
            .mode   (mode[2*i +: 2]),
            .delay  (delay[CNT_W*i +: CNT_W]),
            .pulse  (pulse[i]),
            .busy   (busy[i])
        );
    end

endmodule
